color_channel_filter: RTL and testbench

COLOR_CHANNEL_FILTER -- requirements
Module: color_channel_filter

---
 rtl/color_filter_pkg.sv | 42 ++++
 rtl/color_channel_filter_if.sv | 24 ++
 rtl/channel_op.sv | 38 +++
 rtl/color_channel_filter.sv | 180 ++++++++++++++++++
 tb/tb_color_channel_filter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_filter_pkg.sv
// Shared definitions for the colour channel filter: mode codes, gain format,
// and the pixel order inside the 3x3 window bus.
package color_filter_pkg;

  typedef enum logic [2:0] {
    ModePass   = 3'd0,
    ModeGain   = 3'd1,
    ModeGray   = 3'd2,
    ModeInvert = 3'd3,
    ModeSmooth = 3'd4
  } mode_e;

  // Gains are unsigned fixed point; 1.0 == (1 << GainFrac).
  localparam int unsigned GainFrac = 4;

  // Window pixel indices, counted from the MSB end of the window bus.
  localparam int unsigned WinPixels    = 9;
  localparam int unsigned WinCentre    = 0;
  localparam int unsigned WinLeft      = 1;
  localparam int unsigned WinRight     = 2;
  localparam int unsigned WinUp        = 3;
  localparam int unsigned WinDown      = 4;
  localparam int unsigned WinUpLeft    = 5;
  localparam int unsigned WinUpRight   = 6;
  localparam int unsigned WinDownLeft  = 7;
  localparam int unsigned WinDownRight = 8;

  // Unused codes fold onto PASS so downstream logic only sees legal modes.
  function automatic mode_e to_mode(input logic [2:0] code);
    mode_e m;
    m = ModePass;
    case (code)
      3'd1:    m = ModeGain;
      3'd2:    m = ModeGray;
      3'd3:    m = ModeInvert;
      3'd4:    m = ModeSmooth;
      default: m = ModePass;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/color_channel_filter_if.sv
// Pixel stream bundle for the colour channel filter: window input handshake
// and filtered-pixel output handshake.
interface color_channel_filter_if #(
  parameter int unsigned CW = 4
);
  logic [27*CW-1:0] in_window;
  logic             in_sof;
  logic             in_valid;
  logic             in_ready;
  logic [3*CW-1:0]  out_pixel;
  logic             out_sof;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_window, in_sof, in_valid, out_ready,
    input  in_ready, out_pixel, out_sof, out_valid
  );

  modport slave (
    input  in_window, in_sof, in_valid, out_ready,
    output in_ready, out_pixel, out_sof, out_valid
  );
endinterface

// File: rtl/channel_op.sv
// Single-channel arithmetic for GAIN, INVERT and SMOOTH; other modes pass the
// centre value. Result is left unsaturated at CW+GW bits.
module channel_op
  import color_filter_pkg::*;
#(
  parameter int unsigned CW = 4,
  parameter int unsigned GW = 8
) (
  input  mode_e            mode,
  input  logic [CW-1:0]    centre,
  input  logic [CW-1:0]    left,
  input  logic [CW-1:0]    right,
  input  logic [CW-1:0]    up,
  input  logic [CW-1:0]    down,
  input  logic [GW-1:0]    gain,
  output logic [CW+GW-1:0] result
);
  localparam int unsigned RW = CW + GW;
  localparam int unsigned SW = CW + 3;

  logic [RW-1:0] product;
  logic [SW-1:0] smooth_sum;
  logic [CW-1:0] inverted;

  always_comb begin
    product    = RW'(centre) * RW'(gain);
    // 4*centre plus four neighbours never exceeds 8*(2^CW-1), so CW+3 bits hold it.
    smooth_sum = (SW'(centre) << 2) + SW'(left) + SW'(right) + SW'(up) + SW'(down);
    inverted   = ~centre;
    result     = RW'(centre);
    case (mode)
      ModeGain:   result = product >> GainFrac;
      ModeInvert: result = RW'(inverted);
      ModeSmooth: result = RW'(smooth_sum >> 3);
      default:    result = RW'(centre);
    endcase
  end
endmodule

// File: rtl/color_channel_filter.sv
// Three-stage colour filter: S1 captures window and active config, S2 computes
// the mode result, S3 saturates, masks and drives the output handshake.
module color_channel_filter
  import color_filter_pkg::*;
#(
  parameter int unsigned CW = 4,
  parameter int unsigned GW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  color_channel_filter_if.slave bus,
  input  logic [2:0]            cfg_mode,
  input  logic [2:0]            cfg_mask,
  input  logic [GW-1:0]         cfg_gain_r,
  input  logic [GW-1:0]         cfg_gain_g,
  input  logic [GW-1:0]         cfg_gain_b,
  input  logic                  cfg_load
);
  localparam int unsigned PW = 3 * CW;
  localparam int unsigned RW = CW + GW;
  localparam logic [GW-1:0] GainOne = GW'(1 << GainFrac);
  localparam logic [RW-1:0] ChMax   = RW'({CW{1'b1}});

  function automatic logic [PW-1:0] win_px(input logic [9*PW-1:0] w, input int unsigned idx);
    return w[(WinPixels - 1 - idx) * PW +: PW];
  endfunction

  logic advance, accept, sof_accept;
  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign advance      = bus.in_ready;
  assign accept       = advance & bus.in_valid;
  assign sof_accept   = accept & bus.in_sof;

  logic unused_corners;
  assign unused_corners = ^{win_px(bus.in_window, WinUpLeft), win_px(bus.in_window, WinUpRight),
                            win_px(bus.in_window, WinDownLeft),
                            win_px(bus.in_window, WinDownRight)};

  // Shadow config, and the active config that only follows it at frame start.
  mode_e                sh_mode, act_mode, nxt_mode, use_mode;
  logic [2:0]           sh_mask, act_mask, nxt_mask, use_mask;
  logic [2:0][GW-1:0]   sh_gain, act_gain, nxt_gain, use_gain;

  always_comb begin
    nxt_mode = sh_mode;
    nxt_mask = sh_mask;
    nxt_gain = sh_gain;
    if (cfg_load) begin
      nxt_mode = to_mode(cfg_mode);
      nxt_mask = cfg_mask;
      nxt_gain = {cfg_gain_r, cfg_gain_g, cfg_gain_b};
    end
    use_mode = sof_accept ? nxt_mode : act_mode;
    use_mask = sof_accept ? nxt_mask : act_mask;
    use_gain = sof_accept ? nxt_gain : act_gain;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_mode  <= ModePass;
      sh_mask  <= 3'b111;
      sh_gain  <= {3{GainOne}};
      act_mode <= ModePass;
      act_mask <= 3'b111;
      act_gain <= {3{GainOne}};
    end else begin
      sh_mode <= nxt_mode;
      sh_mask <= nxt_mask;
      sh_gain <= nxt_gain;
      if (sof_accept) begin
        act_mode <= nxt_mode;
        act_mask <= nxt_mask;
        act_gain <= nxt_gain;
      end
    end
  end

  // Stage 1
  logic               s1_valid, s1_sof;
  logic [PW-1:0]      s1_c, s1_l, s1_r, s1_u, s1_d;
  mode_e              s1_mode;
  logic [2:0]         s1_mask;
  logic [2:0][GW-1:0] s1_gain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_c     <= '0;
      s1_l     <= '0;
      s1_r     <= '0;
      s1_u     <= '0;
      s1_d     <= '0;
      s1_mode  <= ModePass;
      s1_mask  <= '0;
      s1_gain  <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_sof   <= bus.in_sof;
      s1_c     <= win_px(bus.in_window, WinCentre);
      s1_l     <= win_px(bus.in_window, WinLeft);
      s1_r     <= win_px(bus.in_window, WinRight);
      s1_u     <= win_px(bus.in_window, WinUp);
      s1_d     <= win_px(bus.in_window, WinDown);
      s1_mode  <= use_mode;
      s1_mask  <= use_mask;
      s1_gain  <= use_gain;
    end
  end

  // Stage 2: channel index 2 is R, 0 is B.
  logic [2:0][RW-1:0] op_res, s2_res_d, s2_res;
  logic [CW+3:0]      gray_sum;
  logic [CW-1:0]      gray;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    channel_op #(
      .CW(CW),
      .GW(GW)
    ) u_op (
      .mode  (s1_mode),
      .centre(s1_c[c*CW +: CW]),
      .left  (s1_l[c*CW +: CW]),
      .right (s1_r[c*CW +: CW]),
      .up    (s1_u[c*CW +: CW]),
      .down  (s1_d[c*CW +: CW]),
      .gain  (s1_gain[c]),
      .result(op_res[c])
    );
  end

  always_comb begin
    gray_sum = (CW+4)'(5) * (CW+4)'(s1_c[2*CW +: CW])
             + (CW+4)'(9) * (CW+4)'(s1_c[CW +: CW])
             + (CW+4)'(2) * (CW+4)'(s1_c[0 +: CW]);
    gray     = CW'(gray_sum >> 4);
    s2_res_d = op_res;
    if (s1_mode == ModeGray) s2_res_d = {3{RW'(gray)}};
  end

  logic       s2_valid, s2_sof;
  logic [2:0] s2_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_mask  <= '0;
      s2_res   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_mask  <= s1_mask;
      s2_res   <= s2_res_d;
    end
  end

  // Stage 3
  logic [PW-1:0] out_d;

  always_comb begin
    out_d = '0;
    for (int c = 0; c < 3; c++) begin
      if (s2_mask[c]) out_d[c*CW +: CW] = (s2_res[c] > ChMax) ? {CW{1'b1}} : CW'(s2_res[c]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_pixel <= '0;
    end else if (advance) begin
      bus.out_valid <= s2_valid;
      bus.out_sof   <= s2_sof;
      bus.out_pixel <= out_d;
    end
  end

endmodule

// File: tb/tb_color_channel_filter.sv
// Directed bench for color_channel_filter: scoreboard of {sof, pixel} filled on
// input transfer and drained by an output monitor.
module tb_color_channel_filter;
  localparam int unsigned CW = 4;
  localparam int unsigned GW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    cfg_mode, cfg_mask;
  logic [GW-1:0] cfg_gain_r, cfg_gain_g, cfg_gain_b;
  logic          cfg_load;

  color_channel_filter_if #(.CW(CW)) bus ();

  color_channel_filter #(
    .CW(CW),
    .GW(GW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cfg_mode  (cfg_mode),
    .cfg_mask  (cfg_mask),
    .cfg_gain_r(cfg_gain_r),
    .cfg_gain_g(cfg_gain_g),
    .cfg_gain_b(cfg_gain_b),
    .cfg_load  (cfg_load)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] sb[$];

  // Bench-side config model.
  logic [2:0]         sh_mode, act_mode, sh_mask, act_mask;
  logic [2:0][GW-1:0] sh_gain, act_gain;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [107:0] mk_win(input logic [11:0] c, l, r, u, d);
    return {c, l, r, u, d, 48'h0};
  endfunction

  function automatic logic [11:0] model(input logic [107:0] w, input logic [2:0] mode,
                                         input logic [2:0] mask, input logic [2:0][7:0] g);
    logic [11:0] c, l, r, u, d, res;
    int v, y, ch;
    c = w[107:96]; l = w[95:84]; r = w[83:72]; u = w[71:60]; d = w[59:48];
    y = (5 * c[11:8] + 9 * c[7:4] + 2 * c[3:0]) / 16;
    res = '0;
    for (int k = 0; k < 3; k++) begin
      ch = c[k*4 +: 4];
      case (mode)
        3'd1: begin
          v = (ch * int'(g[k])) / 16;
          if (v > 15) v = 15;
        end
        3'd2: v = y;
        3'd3: v = 15 - ch;
        3'd4: v = (4 * ch + l[k*4 +: 4] + r[k*4 +: 4] + u[k*4 +: 4] + d[k*4 +: 4]) / 8;
        default: v = ch;
      endcase
      if (mask[k]) res[k*4 +: 4] = v[3:0];
    end
    return res;
  endfunction

  task automatic set_cfg(input logic [2:0] m, input logic [2:0] mask,
                         input logic [7:0] gr, input logic [7:0] gg, input logic [7:0] gb);
    cfg_mode = m; cfg_mask = mask;
    cfg_gain_r = gr; cfg_gain_g = gg; cfg_gain_b = gb;
  endtask

  task automatic capture_shadow();
    sh_mode = cfg_mode; sh_mask = cfg_mask;
    sh_gain = {cfg_gain_r, cfg_gain_g, cfg_gain_b};
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    capture_shadow();
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [107:0] w, input logic sof, input logic ld,
                      input logic use_exp, input logic [11:0] exp_px);
    int waited;
    waited = 0;
    bus.in_window = w; bus.in_sof = sof; bus.in_valid = 1'b1; cfg_load = ld;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $error("FAIL send_timeout: in_ready observed 0 expected 1");
    end else begin
      @(posedge clk); #1;
      if (ld) capture_shadow();
      if (sof) begin
        act_mode = sh_mode; act_mask = sh_mask; act_gain = sh_gain;
      end
      sb.push_back({sof, use_exp ? exp_px : model(w, act_mode, act_mask, act_gain)});
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $error("FAIL drain: pending beats observed %0d expected 0", sb.size());
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $error("FAIL out_unexpected: observed %h expected no beat", {bus.out_sof, bus.out_pixel});
      end else begin
        check("out_beat", {bus.out_sof, bus.out_pixel}, sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.in_window = '0; bus.in_sof = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cfg_load = 1'b0;
    set_cfg(3'd0, 3'b111, 8'h10, 8'h10, 8'h10);
    capture_shadow();
    act_mode = sh_mode; act_mask = sh_mask; act_gain = sh_gain;

    #12;
    check("rst_out_valid", 13'(bus.out_valid), 13'd0);
    check("rst_out_pixel", 13'(bus.out_pixel), 13'd0);
    check("rst_out_sof", 13'(bus.out_sof), 13'd0);
    check("rst_in_ready", 13'(bus.in_ready), 13'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset config is PASS / 111
    send(mk_win(12'h5A3, 12'h111, 12'h222, 12'h333, 12'h444), 1'b0, 1'b0, 1'b1, 12'h5A3);
    drain();

    // PASS with blue removed, with latency check
    set_cfg(3'd0, 3'b110, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'hABC, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'hAB0);
    @(negedge clk); check("lat_edge1", 13'(bus.out_valid), 13'd0);
    @(negedge clk); check("lat_edge2", 13'(bus.out_valid), 13'd0);
    @(negedge clk); check("lat_edge3", 13'(bus.out_valid), 13'd1);
    @(posedge clk); #1;
    drain();

    set_cfg(3'd1, 3'b111, 8'h20, 8'h08, 8'h10);
    pulse_load();
    send(mk_win(12'h9A7, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'hF57);
    set_cfg(3'd2, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'hF00, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'h444);
    set_cfg(3'd4, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'h888, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'h444);
    send(mk_win(12'hF3C, 12'hFFF, 12'h1E0, 12'h7A5, 12'hC0F), 1'b0, 1'b0, 1'b0, 12'h0);
    set_cfg(3'd7, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'h3C5, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'h3C5);
    // Load coinciding with the sof beat applies to that beat
    set_cfg(3'd3, 3'b011, 8'h10, 8'h10, 8'h10);
    send(mk_win(12'h123, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b1, 1'b1, 12'h0DC);
    drain();

    // Mid-frame load only takes effect at the next frame
    set_cfg(3'd0, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'h123, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'h123);
    set_cfg(3'd3, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'h123, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0, 1'b1, 12'h123);
    send(mk_win(12'h123, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0, 1'b1, 12'h123);
    send(mk_win(12'h123, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b1, 12'hEDC);
    send(mk_win(12'h456, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0, 1'b1, 12'hBA9);
    drain();

    // 20-beat stream with a 5-cycle output stall
    set_cfg(3'd4, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [107:0] w;
          w = mk_win(12'(i * 293 + 17), 12'($urandom), 12'($urandom), 12'($urandom),
                     12'($urandom));
          if (i == 10) set_cfg(3'd0, 3'b101, 8'h10, 8'h10, 8'h10);
          send(w, (i == 0) || (i == 10), i == 10, 1'b0, 12'h0);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 13'(bus.in_ready), 13'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a full pipeline and non-default config
    bus.out_ready = 1'b0;
    set_cfg(3'd3, 3'b111, 8'h10, 8'h10, 8'h10);
    pulse_load();
    send(mk_win(12'h111, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1, 1'b0, 1'b0, 12'h0);
    send(mk_win(12'h222, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0, 1'b0, 12'h0);
    send(mk_win(12'h333, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0, 1'b0, 12'h0);
    @(negedge clk);
    check("prerst_out_valid", 13'(bus.out_valid), 13'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 13'(bus.out_valid), 13'd0);
    check("async_rst_pixel", 13'(bus.out_pixel), 13'd0);
    sb.delete();
    set_cfg(3'd0, 3'b111, 8'h10, 8'h10, 8'h10);
    capture_shadow();
    act_mode = sh_mode; act_mask = sh_mask; act_gain = sh_gain;
    bus.out_ready = 1'b1;
    set_cfg(3'd3, 3'b000, 8'h33, 8'h33, 8'h33);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 13'(bus.in_ready), 13'd1);
    @(posedge clk); #1;
    send(mk_win(12'h123, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0, 1'b0, 1'b0, 12'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
